// File: rtl/job_initiator.sv
// job_initiator: host-side initiator for the start / data_valid / done job
// handshake. Takes one byte from the host, pushes it to the responder, waits
// for completion, retries on error or timeout, and reports a single result.
module job_initiator #(
  parameter int                 DATA_W    = 8,
  parameter int                 TIMEOUT   = 16,
  parameter int                 MAX_RETRY = 2,
  parameter logic [DATA_W-1:0]  OK_CODE   = 8'hAA,
  parameter logic [DATA_W-1:0]  ERR_CODE  = 8'hEE
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  input  logic [DATA_W-1:0] req_data,
  output logic              req_ready,
  output logic              tgt_start,
  output logic              tgt_data_valid,
  output logic [DATA_W-1:0] tgt_data,
  input  logic              tgt_ready,
  input  logic              tgt_done,
  input  logic [DATA_W-1:0] tgt_result,
  output logic              res_valid,
  output logic [1:0]        res_status,
  output logic [DATA_W-1:0] res_data,
  output logic [1:0]        res_retries,
  output logic              busy
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);
  localparam logic [1:0]    RETRY_MAX = 2'(MAX_RETRY);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WRDY   = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_WDONE  = 3'd4;
  localparam logic [2:0] S_REPORT = 3'd5;

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_BAD = 2'b01;
  localparam logic [1:0] ST_ERR = 2'b10;
  localparam logic [1:0] ST_TMO = 2'b11;

  logic [2:0]        state, state_nxt;
  logic [TW-1:0]     tmr;
  logic [1:0]        retry;
  logic [DATA_W-1:0] hold;
  logic              tmr_clr, retry_inc, fin, tmo, can_retry, accept;
  logic [1:0]        fin_status, fail_status;

  assign tmo       = (tmr == TMR_LAST);
  assign can_retry = (retry < RETRY_MAX);
  assign accept    = (state == S_IDLE) && req_valid;
  // done wins over the error pattern; the error pattern wins over timeout
  assign fail_status = (tgt_result == ERR_CODE) ? ST_ERR : ST_TMO;

  // next-state decode plus the one-cycle control strobes for the datapath
  always_comb begin
    state_nxt  = state;
    tmr_clr    = 1'b0;
    retry_inc  = 1'b0;
    fin        = 1'b0;
    fin_status = ST_OK;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          state_nxt = S_WRDY;
          tmr_clr   = 1'b1;
        end
      end
      S_WRDY: begin
        if (tgt_ready) begin
          state_nxt = S_START;
        end else if (tmo) begin
          if (can_retry) begin
            // re-entering WAIT_RDY still restarts the per-attempt timer
            retry_inc = 1'b1;
            tmr_clr   = 1'b1;
          end else begin
            fin        = 1'b1;
            fin_status = ST_TMO;
            state_nxt  = S_REPORT;
          end
        end
      end
      S_START: state_nxt = S_DATA;
      S_DATA: begin
        state_nxt = S_WDONE;
        tmr_clr   = 1'b1;
      end
      S_WDONE: begin
        if (tgt_done) begin
          fin        = 1'b1;
          fin_status = (tgt_result == OK_CODE) ? ST_OK : ST_BAD;
          state_nxt  = S_REPORT;
        end else if ((tgt_result == ERR_CODE) || tmo) begin
          if (can_retry) begin
            retry_inc = 1'b1;
            tmr_clr   = 1'b1;
            state_nxt = S_WRDY;
          end else begin
            fin        = 1'b1;
            fin_status = fail_status;
            state_nxt  = S_REPORT;
          end
        end
      end
      S_REPORT: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // state register and saturating per-attempt timer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      tmr   <= '0;
    end else begin
      state <= state_nxt;
      if (tmr_clr)
        tmr <= '0;
      else if (tmr != TMR_LAST)
        tmr <= tmr + TW'(1);
    end
  end

  // request hold, retry count and the result registers captured into REPORT
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold        <= '0;
      retry       <= '0;
      res_status  <= ST_OK;
      res_data    <= '0;
      res_retries <= '0;
    end else begin
      if (accept) begin
        hold  <= req_data;
        retry <= '0;
      end else if (retry_inc) begin
        retry <= retry + 2'd1;
      end
      if (fin) begin
        res_status  <= fin_status;
        res_data    <= tgt_result;
        res_retries <= retry;
      end
    end
  end

  assign req_ready      = (state == S_IDLE);
  assign busy           = (state != S_IDLE);
  assign tgt_start      = (state == S_START);
  assign tgt_data_valid = (state == S_DATA);
  assign res_valid      = (state == S_REPORT);
  // byte is presented from START until the attempt leaves WAIT_DONE
  assign tgt_data = ((state == S_START) || (state == S_DATA) || (state == S_WDONE))
                    ? hold : '0;

endmodule

// File: doc/job_initiator.md
Name: job_initiator

Overview:
- Initiator side of the single-byte start/data_valid/done job handshake; drives a downstream processing FSM (the responder).
- Accepts one byte from a host request port, runs start → data → wait-for-completion against the responder, and classifies the outcome.
- Retries on responder error or timeout, then reports one status/data result to the host.

Parameters:
- DATA_W, 8, width of request byte and responder result byte.
- TIMEOUT, 16, max cycles spent in WAIT_RDY or WAIT_DONE per attempt (≥2).
- MAX_RETRY, 2, extra attempts after the first (0..3).
- OK_CODE, 8'hAA, responder result value meaning success.
- ERR_CODE, 8'hEE, responder result value meaning error when seen with done low.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  host request present.
- req_data  in  DATA_W  host byte to send.
- req_ready  out  1  block idle, can accept request.
- tgt_start  out  1  start pulse to responder.
- tgt_data_valid  out  1  data-valid strobe to responder.
- tgt_data  out  DATA_W  byte to responder.
- tgt_ready  in  1  responder idle.
- tgt_done  in  1  responder completion.
- tgt_result  in  DATA_W  responder result byte.
- res_valid  out  1  one-cycle result pulse.
- res_status  out  2  00 OK, 01 BAD_DATA, 10 ERR, 11 TIMEOUT.
- res_data  out  DATA_W  captured tgt_result.
- res_retries  out  2  retries used for the reported job.
- busy  out  1  high whenever state ≠ IDLE.

Behaviour:
- States: IDLE, WAIT_RDY, START, DATA, WAIT_DONE, REPORT.
- All outputs are Moore-decoded from registered state and datapath only; there is no combinational input-to-output path.
- Reset (async, reset_n=0) forces:
  - state=IDLE; req_ready=1.
  - tgt_start, tgt_data_valid, res_valid, busy all 0.
  - tgt_data, res_data = 0; res_status=00; res_retries=0.
  - Internal counters = 0.
- Reset mid-job abandons the job silently; no res_valid is produced.
- IDLE:
  - req_ready=1.
  - On req_valid, latch req_data into a hold register, clear the retry count, and go to WAIT_RDY.
- WAIT_RDY:
  - Timer is cleared on entry.
  - tgt_ready=1 → START.
  - Timer reaching TIMEOUT-1 → timeout event.
- START: tgt_start=1 for exactly one cycle → DATA.
- DATA: tgt_data_valid=1 and tgt_data=held byte for exactly one cycle → WAIT_DONE.
  - tgt_data holds the byte from START through WAIT_DONE; it is 0 otherwise.
- WAIT_DONE (timer cleared on entry). Checks in priority order:
  - tgt_done=1: capture tgt_result. Status=OK if tgt_result==OK_CODE, else BAD_DATA. → REPORT. No retry.
  - tgt_done=0 and tgt_result==ERR_CODE: error event.
  - Timer reaching TIMEOUT-1: timeout event.
- Error or timeout event:
  - If retry count < MAX_RETRY, increment it and go to WAIT_RDY.
  - Otherwise capture tgt_result, set status ERR or TIMEOUT, and go to REPORT.
  - done and the ERR pattern in the same cycle resolve as done.
- REPORT:
  - res_valid=1 for one cycle → IDLE.
  - res_status, res_data and res_retries update on entry to REPORT and hold until the next REPORT.
- Latency: request accepted at cycle T0 with tgt_ready already high gives tgt_start at T2, tgt_data_valid at T3, and WAIT_DONE from T4.
  - Done seen at cycle Td gives res_valid at Td+1.
- Timer width is clog2(TIMEOUT); it saturates and never wraps.
- A req_valid arriving while busy is ignored (req_ready=0); the host must hold it.

Test Plan:
- Reset then req_data=8'h5C with a responder model that asserts done one cycle after data_valid with result 8'hAA → tgt_start at T2, tgt_data_valid with tgt_data=8'h5C at T3, res_valid with status 00, res_data 8'hAA, res_retries 0.
- Responder returns done with result 8'h11 → status 01, res_data 8'h11, no retry.
- Responder shows result 8'hEE with done=0 on every attempt (MAX_RETRY=2) → three tgt_start pulses, then status 10, res_retries 2.
- tgt_ready held low → WAIT_RDY times out at 16 cycles per attempt, then status 11 after three attempts, with no tgt_start ever asserted.
- First attempt errors, second completes with 8'hAA → status 00, res_retries 1.
- reset_n pulsed low during WAIT_DONE → all outputs immediately at reset values, no res_valid, next request completes normally; also check done and 8'hEE in the same cycle resolve as BAD_DATA/OK by code and not as an error.
